gray_sync_decoder: RTL and testbench
====================================

GRAY_SYNC_DECODER -- requirements
Module: gray_sync_decoder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the Gray/binary code width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all registers update on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port gray_in, input, WIDTH bits: Gray code from a foreign domain, treated as asynchronous.
REQ-005 The block SHALL have port out_ready, input, 1 bit: consumer accepts bin_out when high with out_valid.
REQ-006 The block SHALL have port err_clr, input, 1 bit: synchronous clear of sticky flags.
REQ-007 The block SHALL have port bin_out, output, WIDTH bits: decoded binary value, registered.
REQ-008 The block SHALL have port out_valid, output, 1 bit: bin_out holds an unaccepted new value.
REQ-009 The block SHALL have port dir, output, 1 bit: 1 = last step up (+1), 0 = down (-1) or invalid step.
REQ-010 The block SHALL have port step_err, output, 1 bit: sticky; a change other than +/-1 was seen.
REQ-011 The block SHALL have port ovf, output, 1 bit: sticky; a change was dropped while out_valid was high and out_ready low.

Function
REQ-012 The block SHALL synchronise gray_in through registers s1 then s2, with no logic between stages.
REQ-013 The block SHALL keep register prev, loaded with s2 every cycle; a change event SHALL be s2 != prev.
REQ-014 On a change event, the block SHALL decode s2 to binary: b[W-1] = g[W-1], b[i] = b[i+1] ^ g[i].
REQ-015 The block SHALL compute step = bin(s2) - bin(prev) modulo 2^WIDTH.
REQ-016 A step of 1 SHALL set dir = 1.
REQ-017 A step of 2^WIDTH-1 SHALL set dir = 0.
REQ-018 Any other step SHALL set dir = 0 and set step_err.
REQ-019 Wrap-around SHALL be a legal step: 15 -> 0 is up and 0 -> 15 is down (WIDTH = 4).
REQ-020 Latency SHALL be 3 rising edges from gray_in stable before edge E1 to bin_out/out_valid updated after edge E3.
REQ-021 On a change event with out_valid = 0 or out_ready = 1, the block SHALL register bin_out, dir and out_valid = 1 at the next edge.
REQ-022 On a change event with out_valid = 1 and out_ready = 0, the block SHALL hold bin_out and dir unchanged, drop the new value and set ovf.
REQ-023 With no change event, out_valid = 1 and out_ready = 1 SHALL clear out_valid at the next edge.
REQ-024 Simultaneous acceptance and change event SHALL load the new value and keep out_valid = 1.
REQ-025 step_err and ovf SHALL clear on err_clr = 1; if a set condition occurs in the same cycle, set SHALL win.
REQ-026 step_err SHALL still be evaluated on dropped (overflowed) changes.
REQ-027 prev SHALL always track s2, including when a change is dropped.

Reset
REQ-028 rst_n = 0 SHALL immediately clear s1, s2, prev, bin_out, out_valid, dir, step_err and ovf to 0, regardless of clk.
REQ-029 After reset release, a nonzero gray_in SHALL be treated as a change from 0, including step checking.
REQ-030 Reset asserted mid-pipeline SHALL discard all in-flight samples; no out_valid SHALL follow from pre-reset samples.

Configuration
REQ-031 With macro GRAY_SYNC_STAGE3_EN defined, the block SHALL insert a third synchroniser stage s3 between s2 and the decode/compare, with prev tracking s3.
REQ-032 With GRAY_SYNC_STAGE3_EN defined, latency SHALL be 4 edges; s3 SHALL reset to 0.
REQ-033 With GRAY_SYNC_STAGE3_EN undefined, the block SHALL use exactly two stages and 3-edge latency; all other behaviour SHALL be identical.

Verification (WIDTH = 4, two-stage build unless noted)
REQ-034 Reset: rst_n = 0 with gray_in = 4'b1010 -> all outputs 0 immediately; out_valid stays 0 during reset.
REQ-035 Up step: gray_in 0000 -> 0001, out_ready = 1 -> after 3 edges bin_out = 0001, out_valid high for exactly 1 cycle, dir = 1, step_err = 0.
REQ-036 Down step: gray_in 0011 (bin 2) -> 0001 (bin 1) -> bin_out = 0001, dir = 0, step_err = 0; wrap check: gray_in 1000 (bin 15) -> 0000 gives dir = 1, no error.
REQ-037 Bad step: gray_in 0001 (bin 1) -> 0010 (bin 3) -> bin_out = 0011, dir = 0, step_err = 1 until err_clr pulse, then 0.
REQ-038 Backpressure: out_ready = 0, gray_in 0000 -> 0001 -> 0011 (changes 4 cycles apart) -> bin_out holds 0001, out_valid = 1, ovf = 1; raising out_ready clears out_valid next edge.
REQ-039 Macro: build with GRAY_SYNC_STAGE3_EN, repeat the REQ-035 stimulus -> bin_out = 0001 after 4 edges, not 3.

Source files
------------

// File: rtl/gray_sync_decoder.sv
// gray_sync_decoder: synchronises an async Gray count, decodes it and reports direction, step errors and overflow.
// Define GRAY_SYNC_STAGE3_EN for a third synchroniser stage (4-edge latency instead of 3).
module gray_sync_decoder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] gray_in,
    input  logic             out_ready,
    input  logic             err_clr,
    output logic [WIDTH-1:0] bin_out,
    output logic             out_valid,
    output logic             dir,
    output logic             step_err,
    output logic             ovf
);
    logic [WIDTH-1:0] s1_q, s2_q, prev_q, bin_q, bin_d, cmp, cur_bin, prev_bin, step;
    logic             valid_q, valid_d, dir_q, dir_d, err_q, err_d, ovf_q, ovf_d;
    logic             chg, accept, load, bad;

    function automatic logic [WIDTH-1:0] g2b(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

`ifdef GRAY_SYNC_STAGE3_EN
    logic [WIDTH-1:0] s3_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) s3_q <= '0;
        else        s3_q <= s2_q;
    end
    assign cmp = s3_q;
`else
    assign cmp = s2_q;
`endif

    always_comb begin
        cur_bin  = g2b(cmp);
        prev_bin = g2b(prev_q);
        step     = cur_bin - prev_bin;
        chg      = cmp != prev_q;
        accept   = !valid_q || out_ready;
        load     = chg && accept;
        bad      = chg && step != {{(WIDTH-1){1'b0}}, 1'b1} && step != '1;
        bin_d    = load ? cur_bin : bin_q;
        dir_d    = load ? (step == {{(WIDTH-1){1'b0}}, 1'b1}) : dir_q;
        valid_d  = load ? 1'b1 : (valid_q && !out_ready);
        // Setting a sticky flag takes priority over a same-cycle clear.
        err_d    = bad ? 1'b1 : (err_clr ? 1'b0 : err_q);
        ovf_d    = (chg && !accept) ? 1'b1 : (err_clr ? 1'b0 : ovf_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q    <= '0;
            s2_q    <= '0;
            prev_q  <= '0;
            bin_q   <= '0;
            valid_q <= 1'b0;
            dir_q   <= 1'b0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            s1_q    <= gray_in;
            s2_q    <= s1_q;
            prev_q  <= cmp;
            bin_q   <= bin_d;
            valid_q <= valid_d;
            dir_q   <= dir_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bin_out   = bin_q;
    assign out_valid = valid_q;
    assign dir       = dir_q;
    assign step_err  = err_q;
    assign ovf       = ovf_q;
endmodule

// File: tb/tb_gray_sync_decoder.sv
// tb_gray_sync_decoder: vector table plus hand sequences; accepted outputs are checked against a scoreboard queue.
module tb_gray_sync_decoder;
`ifdef GRAY_SYNC_STAGE3_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif
    logic       clk = 0, rst_n = 1, out_ready = 1, err_clr = 0;
    logic [3:0] gray_in = 0;
    logic [3:0] bin_out;
    logic       out_valid, dir, step_err, ovf;

    typedef struct packed {logic [3:0] bin; logic dir;} exp_t;
    typedef struct {logic [3:0] gray; logic [3:0] bin; logic dir; logic err; logic clr;} vec_t;
    exp_t sb_q[$];
    exp_t sb_e;
    vec_t vt[9];
    int   checks = 0, errors = 0;

    gray_sync_decoder #(.WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .gray_in(gray_in), .out_ready(out_ready), .err_clr(err_clr),
        .bin_out(bin_out), .out_valid(out_valid), .dir(dir), .step_err(step_err), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // A handshake seen here completes on the next rising edge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected got bin %0h want none", bin_out);
            end else begin
                sb_e = sb_q.pop_front();
                chk("sb_bin", bin_out, sb_e.bin);
                chk("sb_dir", dir, sb_e.dir);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout got running want finished");
        $fatal(1);
    end

    initial begin
        vt[0] = '{4'b0011, 4'd2,  1'b1, 1'b0, 1'b0};
        vt[1] = '{4'b0001, 4'd1,  1'b0, 1'b0, 1'b0};
        vt[2] = '{4'b0000, 4'd0,  1'b0, 1'b0, 1'b0};
        vt[3] = '{4'b1000, 4'd15, 1'b0, 1'b0, 1'b0};
        vt[4] = '{4'b0000, 4'd0,  1'b1, 1'b0, 1'b0};
        vt[5] = '{4'b0001, 4'd1,  1'b1, 1'b0, 1'b0};
        vt[6] = '{4'b0010, 4'd3,  1'b0, 1'b1, 1'b1};
        vt[7] = '{4'b0110, 4'd4,  1'b1, 1'b0, 1'b0};
        vt[8] = '{4'b1100, 4'd8,  1'b0, 1'b1, 1'b1};

        // Asynchronous reset with a nonzero input.
        gray_in = 4'b1010;
        #2 rst_n = 0;
        #1;
        chk("rst_bin", bin_out, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_dir", dir, 0);
        chk("rst_err", step_err, 0);
        chk("rst_ovf", ovf, 0);
        for (int i = 0; i < 4; i++) begin
            tick(1);
            chk("rst_hold_valid", out_valid, 0);
        end
        // Release: 1010 (bin 12) is a bad step from 0.
        rst_n = 1;
        sb_q.push_back('{4'd12, 1'b0});
        tick(LAT);
        chk("rel_valid", out_valid, 1);
        chk("rel_bin", bin_out, 12);
        chk("rel_err", step_err, 1);
        tick(2);

        // Reset with a change in flight must not produce output.
        rst_n = 0;
        gray_in = 0;
        tick(2);
        rst_n = 1;
        tick(3);
        gray_in = 4'b0001;
        tick(1);
        rst_n = 0;
        gray_in = 0;
        tick(2);
        rst_n = 1;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            chk("flush_valid", out_valid, 0);
        end
        chk("flush_err", step_err, 0);

        // Latency and single-cycle valid pulse.
        gray_in = 4'b0001;
        sb_q.push_back('{4'd1, 1'b1});
        for (int i = 1; i <= LAT + 1; i++) begin
            tick(1);
            chk("lat_valid", out_valid, i == LAT);
            if (i == LAT) begin
                chk("lat_bin", bin_out, 1);
                chk("lat_dir", dir, 1);
                chk("lat_err", step_err, 0);
            end
        end

        for (int i = 0; i < 9; i++) begin
            gray_in = vt[i].gray;
            sb_q.push_back('{vt[i].bin, vt[i].dir});
            tick(LAT + 2);
            chk("vec_valid", out_valid, 0);
            chk("vec_err", step_err, vt[i].err);
            chk("vec_ovf", ovf, 0);
            if (vt[i].clr) begin
                err_clr = 1;
                tick(1);
                err_clr = 0;
                chk("vec_clr", step_err, 0);
            end
        end

        // Clear coinciding with a bad step: set wins. bin 8 -> 0.
        gray_in = 4'b0000;
        sb_q.push_back('{4'd0, 1'b0});
        tick(LAT - 1);
        err_clr = 1;
        tick(1);
        err_clr = 0;
        chk("setwin_err", step_err, 1);
        tick(2);
        err_clr = 1;
        tick(1);
        err_clr = 0;

        // Backpressure: second change is dropped.
        out_ready = 0;
        gray_in = 4'b0001;
        sb_q.push_back('{4'd1, 1'b1});
        tick(4);
        gray_in = 4'b0011;
        tick(4);
        chk("bp_bin", bin_out, 1);
        chk("bp_valid", out_valid, 1);
        chk("bp_dir", dir, 1);
        chk("bp_ovf", ovf, 1);
        chk("bp_err", step_err, 0);
        out_ready = 1;
        tick(1);
        chk("bp_release_valid", out_valid, 0);
        chk("bp_hold_bin", bin_out, 1);
        err_clr = 1;
        tick(1);
        err_clr = 0;
        chk("bp_ovf_clr", ovf, 0);
        tick(3);
        chk("sb_empty", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
